// File: rtl/select_best_hop_pkg.sv
// Shared neighbor-table layout and state encoding for the Q-learning routing
// datapath; the learnCosts writer uses the same layout constants.
package select_best_hop_pkg;

  localparam int WORD_WIDTH    = 16;
  localparam int ADDR_WIDTH    = 11;
  localparam int INDEX_WIDTH   = 5;
  localparam int ENTRY_BYTES   = 8;
  localparam int MAX_NEIGHBORS = 16;

  localparam logic [ADDR_WIDTH-1:0] TABLE_BASE = 11'h000;
  localparam logic [ADDR_WIDTH-1:0] OFF_ID     = 11'd0;
  localparam logic [ADDR_WIDTH-1:0] OFF_BATT   = 11'd2;
  localparam logic [ADDR_WIDTH-1:0] OFF_VAL    = 11'd4;
  localparam logic [ADDR_WIDTH-1:0] OFF_CLUS   = 11'd6;

  localparam logic [WORD_WIDTH-1:0] MIN_BATTERY = 16'd2;
  localparam logic [WORD_WIDTH-1:0] NO_COST     = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CNT_ADDR = 4'd1,
    CNT_CAP  = 4'd2,
    RD_ID    = 4'd3,
    RD_BATT  = 4'd4,
    RD_VAL   = 4'd5,
    RD_CLUS  = 4'd6,
    CMP      = 4'd7,
    DONE     = 4'd8
  } hop_state_e;

  // Entries follow the count word; arithmetic wraps in the address width.
  function automatic logic [ADDR_WIDTH-1:0] entry_addr(
    input logic [INDEX_WIDTH-1:0] index,
    input logic [ADDR_WIDTH-1:0]  offset
  );
    logic [ADDR_WIDTH-1:0] idx_ext;
    idx_ext = ADDR_WIDTH'(index);
    return TABLE_BASE + ADDR_WIDTH'(2) + idx_ext * ADDR_WIDTH'(ENTRY_BYTES) + offset;
  endfunction

endpackage

// File: rtl/select_best_hop.sv
// Scans the neighbor table and reports the eligible neighbor with the lowest
// learned cost; read-only client of the shared memory port.
module select_best_hop
  import select_best_hop_pkg::*;
(
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] mem_data_out,
  output logic [WORD_WIDTH-1:0] best_id,
  output logic [WORD_WIDTH-1:0] best_value,
  output logic [WORD_WIDTH-1:0] best_cluster,
  output logic                  found,
  output logic                  done,
  output logic [3:0]            state_out
);

  hop_state_e             state, state_n;
  logic [INDEX_WIDTH-1:0] index, index_n;
  logic [INDEX_WIDTH-1:0] count, count_n;
  logic [WORD_WIDTH-1:0]  id_r, id_n;
  logic [WORD_WIDTH-1:0]  batt_r, batt_n;
  logic [WORD_WIDTH-1:0]  val_r, val_n;
  logic [ADDR_WIDTH-1:0]  address_n;
  logic [WORD_WIDTH-1:0]  best_id_n, best_value_n, best_cluster_n;
  logic                   found_n;
  logic                   done_n;

  assign wr_en     = 1'b0;
  assign state_out = state;

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      index        <= '0;
      count        <= '0;
      id_r         <= '0;
      batt_r       <= '0;
      val_r        <= '0;
      address      <= '0;
      best_id      <= '0;
      best_value   <= NO_COST;
      best_cluster <= '0;
      found        <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      index        <= index_n;
      count        <= count_n;
      id_r         <= id_n;
      batt_r       <= batt_n;
      val_r        <= val_n;
      address      <= address_n;
      best_id      <= best_id_n;
      best_value   <= best_value_n;
      best_cluster <= best_cluster_n;
      found        <= found_n;
      done         <= done_n;
    end
  end

  // Read data arrives one cycle after its address, so each field is captured
  // in the state following the one that issued its address.
  always_comb begin
    state_n        = state;
    index_n        = index;
    count_n        = count;
    id_n           = id_r;
    batt_n         = batt_r;
    val_n          = val_r;
    best_id_n      = best_id;
    best_value_n   = best_value;
    best_cluster_n = best_cluster;
    found_n        = found;

    case (state)
      IDLE: begin
        if (en) begin
          best_id_n      = '0;
          best_value_n   = NO_COST;
          best_cluster_n = '0;
          found_n        = 1'b0;
          state_n        = CNT_ADDR;
        end
      end
      CNT_ADDR: state_n = CNT_CAP;
      CNT_CAP: begin
        if (mem_data_out > WORD_WIDTH'(MAX_NEIGHBORS))
          count_n = INDEX_WIDTH'(MAX_NEIGHBORS);
        else
          count_n = mem_data_out[INDEX_WIDTH-1:0];
        index_n = '0;
        state_n = (count_n == '0) ? DONE : RD_ID;
      end
      RD_ID: state_n = RD_BATT;
      RD_BATT: begin
        id_n    = mem_data_out;
        state_n = RD_VAL;
      end
      RD_VAL: begin
        batt_n  = mem_data_out;
        state_n = RD_CLUS;
      end
      RD_CLUS: begin
        val_n   = mem_data_out;
        state_n = CMP;
      end
      CMP: begin
        // Strict less-than keeps the earliest entry on equal cost.
        if ((batt_r >= MIN_BATTERY) && (!found || (val_r < best_value))) begin
          best_id_n      = id_r;
          best_value_n   = val_r;
          best_cluster_n = mem_data_out;
          found_n        = 1'b1;
        end
        index_n = index + INDEX_WIDTH'(1);
        state_n = (index_n == count) ? DONE : RD_ID;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    address_n = address;
    case (state_n)
      IDLE:     address_n = '0;
      CNT_ADDR: address_n = TABLE_BASE;
      RD_ID:    address_n = entry_addr(index_n, OFF_ID);
      RD_BATT:  address_n = entry_addr(index_n, OFF_BATT);
      RD_VAL:   address_n = entry_addr(index_n, OFF_VAL);
      RD_CLUS:  address_n = entry_addr(index_n, OFF_CLUS);
      default:  address_n = address;
    endcase

    done_n = (state_n == DONE);
  end

endmodule

// File: doc/select_best_hop.md
Name: select_best_hop

Overview:
- Reader counterpart of the neighbor-table writer (learnCosts) in the Q-learning routing datapath.
- On a start pulse it scans the neighbor table in shared 16-bit-word memory.
- It returns the eligible neighbor with the lowest learned cost (Value) as next hop, plus that neighbor's cluster ID.
- Shares the same `mem` port (address/wr_en/data) through the top-level memory mux; never writes.

Parameters:
WORD_WIDTH, 16, data word width
ADDR_WIDTH, 11, memory byte-address width
TABLE_BASE, 11'h000, byte address of neighbor-count word; entries start at TABLE_BASE+2
ENTRY_BYTES, 8, bytes per entry: +0 sourceID, +2 batteryStat, +4 Value, +6 clusterID
MAX_NEIGHBORS, 16, clamp for stored count
MIN_BATTERY, 16'd2, entries with batteryStat below this are ineligible

Ports:
clock  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
en  in  1  start pulse, sampled in IDLE only
address  out  ADDR_WIDTH  memory byte address
wr_en  out  1  memory write enable, constant 0
mem_data_out  in  WORD_WIDTH  memory read data, valid one cycle after address
best_id  out  WORD_WIDTH  sourceID of selected neighbor
best_value  out  WORD_WIDTH  Value of selected neighbor
best_cluster  out  WORD_WIDTH  clusterID of selected neighbor
found  out  1  at least one eligible neighbor
done  out  1  one-cycle completion pulse
state_out  out  4  current state encoding, for debug

Behaviour:
- Clock/reset: one clock `clock`; reset `nrst` is asynchronous, active-low.
- Reset values: state IDLE, address 0, wr_en 0, best_id 0, best_value 16'hFFFF, best_cluster 0, found 0, done 0, index 0.
- Memory model: synchronous read. Address driven in cycle N gives mem_data_out valid in cycle N+1. All outputs are registered.
- States and transitions:
  - IDLE: address=0. If en=1, clear best_* and found to reset values; go to CNT_ADDR.
  - CNT_ADDR: address=TABLE_BASE → CNT_CAP.
  - CNT_CAP: count = min(mem_data_out, MAX_NEIGHBORS); index=0. If count=0 → DONE, else → RD_ID.
  - RD_ID: address = entry+0 → RD_BATT.
  - RD_BATT: address = entry+2; capture id → RD_VAL.
  - RD_VAL: address = entry+4; capture batt → RD_CLUS.
  - RD_CLUS: address = entry+6; capture val → CMP.
  - CMP: take clus from mem_data_out. Update best if batt ≥ MIN_BATTERY and (found=0 or val < best_value), then set found=1. index++. If index == count → DONE, else → RD_ID.
  - DONE: done=1 for exactly one cycle → IDLE.
- Entry address: entry = TABLE_BASE + 2 + index*ENTRY_BYTES, computed in ADDR_WIDTH bits; wraps modulo 2^ADDR_WIDTH.
- Latency: if en is sampled at edge k, done is high in the cycle after edge k+2+5·count. Examples: count=0 → after edge k+2; count=3 → after edge k+17.
- Ties: strict less-than, so the lowest index wins on equal Value. Comparison is unsigned 16-bit.
- en while not IDLE: ignored; no restart.
- Result holding: best_*/found hold after done until the next accepted en.
- Empty table, or no eligible entry: found=0; best_* keep reset values.
- Reset mid-scan: immediate return to IDLE with reset values; no done pulse.
- State encoding: IDLE=0, CNT_ADDR=1, CNT_CAP=2, RD_ID=3, RD_BATT=4, RD_VAL=5, RD_CLUS=6, CMP=7, DONE=8.

Decomposition:
- Shared package/include holds:
  - table layout constants: TABLE_BASE, ENTRY_BYTES, field offsets 0/2/4/6, MAX_NEIGHBORS;
  - WORD_WIDTH/ADDR_WIDTH;
  - the state encoding above.
- learnCosts uses the same layout constants.
- No sub-module is warranted; the compare/update is inline in CMP.

Test Plan:
- Preload count=3 with entries (id,batt,val,clus) = (31,5,40,11), (7,5,12,3), (9,5,25,4); pulse en → done in cycle after edge k+17; best_id=7, best_value=12, best_cluster=3, found=1.
- count=0 → done after edge k+2; found=0, best_value=16'hFFFF, best_id=0.
- count=2: (4,1,5,2) and (6,3,20,8) with MIN_BATTERY=2 → low-battery entry skipped; best_id=6, best_value=20.
- Tie: (10,5,15,1) and (12,5,15,2) → best_id=10. Then count word=40 → clamps to 16; done after edge k+82; address never exceeds TABLE_BASE+2+15·8+6.
- en re-pulsed during RD_VAL → ignored; single done. Then nrst low during CMP → outputs return to reset values asynchronously; no done; next en scans normally.
- wr_en stays 0 throughout every scenario; state_out sequence in the first test is 0,1,2,(3,4,5,6,7)×3,8,0.
